// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with ALU decode, operand forwarding and load-use interlock (optional FORWARDING_EN)
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [5:0]        alu_control,
  output logic [DATA_W-1:0] alu_read1,
  output logic [DATA_W-1:0] alu_foutput,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_is_load,
  output logic [DATA_W-1:0] ex_store_data
);
  logic [5:0]        op, funct, d_ctl;
  logic              r_ok, i_sx, i_zx, br, ld, st, d_rw, d_use_rt;
  logic [REG_AW-1:0] d_rs, d_rt, d_rd;
  logic [DATA_W-1:0] d_imm;
  logic              use_rt_q, hazard_src, load_use, cap;
  logic [REG_AW-1:0] rs_idx_q, rt_idx_q;
  logic [DATA_W-1:0] rs_q, rt_q, imm_q, fwd_rs, fwd_rt;

  assign op    = in_instr[31:26];
  assign funct = in_instr[5:0];
  assign d_rs  = REG_AW'(in_instr[25:21]);
  assign d_rt  = REG_AW'(in_instr[20:16]);
  assign r_ok  = (op == 6'd0) && (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 ||
                                  funct == 6'd37 || funct == 6'd39 || funct == 6'd42);
  assign i_sx  = op == 6'd8  || op == 6'd10;
  assign i_zx  = op == 6'd12 || op == 6'd13;
  assign br    = op == 6'd4  || op == 6'd5;
  assign ld    = op == 6'd35;
  assign st    = op == 6'd43;
  assign d_ctl = r_ok ? funct : (i_sx | i_zx | br) ? op : (ld | st) ? 6'd32 : 6'd0;
  assign d_rd  = r_ok ? REG_AW'(in_instr[15:11]) : (i_sx | i_zx | ld) ? d_rt : '0;
  assign d_rw  = (r_ok | i_sx | i_zx | ld) && d_rd != '0;
  assign d_use_rt = (op == 6'd0) | br;
  assign d_imm = i_zx ? {{(DATA_W-16){1'b0}}, in_instr[15:0]}
                      : {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};

`ifdef FORWARDING_EN
  // Newest producer wins: EX/MEM before MEM/WB, $0 never forwarded
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] src, input logic [DATA_W-1:0] q);
    return (exmem_regwrite && exmem_rd != '0 && exmem_rd == src) ? exmem_result :
           (memwb_regwrite && memwb_rd != '0 && memwb_rd == src) ? memwb_result : q;
  endfunction
  assign fwd_rs     = fwd(rs_idx_q, rs_q);
  assign fwd_rt     = fwd(rt_idx_q, rt_q);
  assign hazard_src = ex_is_load;
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd,
                        memwb_result, rs_idx_q, rt_idx_q};
  assign fwd_rs     = rs_q;
  assign fwd_rt     = rt_q;
  assign hazard_src = ex_regwrite;
`endif

  assign load_use = out_valid && hazard_src && ex_rd != '0 && in_valid &&
                    (d_rs == ex_rd || (d_use_rt && d_rt == ex_rd));
  assign in_ready = (~out_valid | out_ready) & ~load_use;
  assign cap      = in_valid & in_ready;

  assign alu_read1     = fwd_rs;
  assign alu_foutput   = use_rt_q ? fwd_rt : imm_q;
  assign ex_store_data = fwd_rt;

  // Pipeline register: flush kills, capture loads, drain bubbles, stall refreshes operands
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid   <= 1'b0;
      alu_control <= '0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_is_load  <= 1'b0;
      use_rt_q    <= 1'b0;
      rs_idx_q    <= '0;
      rt_idx_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      imm_q       <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_is_load  <= 1'b0;
    end else if (cap) begin
      out_valid   <= 1'b1;
      alu_control <= d_ctl;
      ex_rd       <= d_rd;
      ex_regwrite <= d_rw;
      ex_is_load  <= ld;
      use_rt_q    <= d_use_rt;
      rs_idx_q    <= d_rs;
      rt_idx_q    <= d_rt;
      rs_q        <= in_rs_data;
      rt_q        <= in_rt_data;
      imm_q       <= d_imm;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end else if (out_valid) begin
      rs_q        <= fwd_rs;
      rt_q        <= fwd_rt;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  logic        clk = 0, reset = 1, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1;
  logic [31:0] in_instr = 0, in_rs_data = 0, in_rt_data = 0;
  logic        exmem_regwrite = 0, memwb_regwrite = 0;
  logic [4:0]  exmem_rd = 0, memwb_rd = 0;
  logic [31:0] exmem_result = 0, memwb_result = 0;
  logic [5:0]  alu_control;
  logic [31:0] alu_read1, alu_foutput, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_is_load;
  int          compared = 0, mismatched = 0;
  logic [31:0] exp_rd1;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .alu_control(alu_control), .alu_read1(alu_read1),
    .alu_foutput(alu_foutput), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1; in_instr = ins; in_rs_data = rs; in_rt_data = rt;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", out_valid); mismatched++; end
    compared++; if (alu_control !== 6'd0) begin $display("FAIL reset_ctl: got %0d want 0", alu_control); mismatched++; end
    compared++; if (ex_rd !== 5'd0 || ex_regwrite !== 1'b0 || ex_is_load !== 1'b0) begin $display("FAIL reset_ctrl: rd=%0d rw=%b ld=%b want 0", ex_rd, ex_regwrite, ex_is_load); mismatched++; end
    compared++; if (alu_read1 !== 32'd0 || ex_store_data !== 32'd0) begin $display("FAIL reset_data: read1=%h st=%h want 0", alu_read1, ex_store_data); mismatched++; end
    reset = 0;
    #1;
    compared++; if (in_ready !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", in_ready); mismatched++; end
  endtask

  task automatic test_addi;
    @(negedge clk); out_ready = 1; drive(32'h2009FFFB, 32'd0, 32'h1234);
    #1;
    compared++; if (in_ready !== 1'b1) begin $display("FAIL addi_ready: got %b want 1", in_ready); mismatched++; end
    @(negedge clk); in_valid = 0;
    compared++; if (out_valid !== 1'b1) begin $display("FAIL addi_valid: got %b want 1", out_valid); mismatched++; end
    compared++; if (alu_control !== 6'd8) begin $display("FAIL addi_ctl: got %0d want 8", alu_control); mismatched++; end
    compared++; if (alu_read1 !== 32'd0) begin $display("FAIL addi_read1: got %h want 0", alu_read1); mismatched++; end
    compared++; if (alu_foutput !== 32'hFFFFFFFB) begin $display("FAIL addi_fout: got %h want fffffffb", alu_foutput); mismatched++; end
    compared++; if (ex_rd !== 5'd9 || ex_regwrite !== 1'b1) begin $display("FAIL addi_rd: rd=%0d rw=%b want 9/1", ex_rd, ex_regwrite); mismatched++; end
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin $display("FAIL addi_bubble: got %b want 0", out_valid); mismatched++; end
  endtask

  task automatic test_ori;
    @(negedge clk); drive(32'h342A8000, 32'h1, 32'h0);
    @(negedge clk); in_valid = 0;
    compared++; if (alu_foutput !== 32'h00008000) begin $display("FAIL ori_fout: got %h want 00008000", alu_foutput); mismatched++; end
    compared++; if (alu_control !== 6'd13 || alu_read1 !== 32'h1 || ex_rd !== 5'd10) begin $display("FAIL ori_ctl: ctl=%0d read1=%h rd=%0d want 13/1/10", alu_control, alu_read1, ex_rd); mismatched++; end
  endtask

  task automatic test_forward;
    @(negedge clk); drive(32'h01095020, 32'h1234, 32'h99);
    exmem_regwrite = 1; exmem_rd = 8; exmem_result = 32'h55;
    memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'h66;
    @(negedge clk); in_valid = 0;
`ifdef FORWARDING_EN
    exp_rd1 = 32'h55;
`else
    exp_rd1 = 32'h1234;
`endif
    compared++; if (alu_read1 !== exp_rd1) begin $display("FAIL fwd_read1: got %h want %h", alu_read1, exp_rd1); mismatched++; end
    compared++; if (alu_foutput !== 32'h99 || alu_control !== 6'd32) begin $display("FAIL fwd_fout: fout=%h ctl=%0d want 99/32", alu_foutput, alu_control); mismatched++; end
    memwb_rd = 9;
    #1;
`ifdef FORWARDING_EN
    exp_rd1 = 32'h66;
`else
    exp_rd1 = 32'h99;
`endif
    compared++; if (alu_foutput !== exp_rd1) begin $display("FAIL fwd_memwb_rt: got %h want %h", alu_foutput, exp_rd1); mismatched++; end
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic test_store_branch_nop;
    @(negedge clk); drive(32'hAD090004, 32'h100, 32'hCAFE);
    @(negedge clk); drive(32'h11090003, 32'h5, 32'h7);
    compared++; if (alu_control !== 6'd32 || alu_foutput !== 32'd4 || alu_read1 !== 32'h100) begin $display("FAIL sw_ops: ctl=%0d fout=%h read1=%h want 32/4/100", alu_control, alu_foutput, alu_read1); mismatched++; end
    compared++; if (ex_store_data !== 32'hCAFE || ex_regwrite !== 1'b0 || ex_is_load !== 1'b0) begin $display("FAIL sw_store: st=%h rw=%b ld=%b want cafe/0/0", ex_store_data, ex_regwrite, ex_is_load); mismatched++; end
    @(negedge clk); drive(32'h08000000, 32'h0, 32'h0);
    compared++; if (alu_control !== 6'd4 || alu_foutput !== 32'h7 || ex_regwrite !== 1'b0) begin $display("FAIL beq: ctl=%0d fout=%h rw=%b want 4/7/0", alu_control, alu_foutput, ex_regwrite); mismatched++; end
    @(negedge clk); drive(32'h01090020, 32'h1, 32'h2);
    compared++; if (out_valid !== 1'b1 || alu_control !== 6'd0 || ex_regwrite !== 1'b0) begin $display("FAIL nop: v=%b ctl=%0d rw=%b want 1/0/0", out_valid, alu_control, ex_regwrite); mismatched++; end
    @(negedge clk); in_valid = 0;
    compared++; if (alu_control !== 6'd32 || ex_rd !== 5'd0 || ex_regwrite !== 1'b0) begin $display("FAIL rd_zero: ctl=%0d rd=%0d rw=%b want 32/0/0", alu_control, ex_rd, ex_regwrite); mismatched++; end
  endtask

  task automatic test_load_use;
    @(negedge clk); drive(32'h8C080000, 32'h0, 32'h0);
    @(negedge clk); drive(32'h01095020, 32'hAAAA, 32'hBB);
    #1;
    compared++; if (ex_is_load !== 1'b1 || ex_regwrite !== 1'b1 || ex_rd !== 5'd8) begin $display("FAIL lw_held: ld=%b rw=%b rd=%0d want 1/1/8", ex_is_load, ex_regwrite, ex_rd); mismatched++; end
    compared++; if (in_ready !== 1'b0) begin $display("FAIL lu_ready: got %b want 0", in_ready); mismatched++; end
    @(negedge clk);
    compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL lu_bubble: v=%b rdy=%b want 0/1", out_valid, in_ready); mismatched++; end
    @(negedge clk); in_valid = 0;
    compared++; if (out_valid !== 1'b1 || alu_control !== 6'd32 || ex_rd !== 5'd10 || alu_read1 !== 32'hAAAA) begin $display("FAIL lu_capture: v=%b ctl=%0d rd=%0d read1=%h want 1/32/10/aaaa", out_valid, alu_control, ex_rd, alu_read1); mismatched++; end
    @(negedge clk);
  endtask

  task automatic test_stall_refresh;
`ifdef FORWARDING_EN
    exp_rd1 = 32'h77;
`else
    exp_rd1 = 32'h11;
`endif
    @(negedge clk); out_ready = 1; drive(32'h01095020, 32'h11, 32'h22);
    @(negedge clk); in_valid = 0; out_ready = 0;
    memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'h77;
    #1;
    compared++; if (alu_read1 !== exp_rd1) begin $display("FAIL stall_c1: got %h want %h", alu_read1, exp_rd1); mismatched++; end
    @(negedge clk); memwb_regwrite = 0; memwb_result = 0;
    #1;
    compared++; if (alu_read1 !== exp_rd1) begin $display("FAIL stall_c2: got %h want %h", alu_read1, exp_rd1); mismatched++; end
    compared++; if (out_valid !== 1'b1 || ex_rd !== 5'd10 || alu_foutput !== 32'h22 || in_ready !== 1'b0) begin $display("FAIL stall_hold: v=%b rd=%0d fout=%h rdy=%b want 1/10/22/0", out_valid, ex_rd, alu_foutput, in_ready); mismatched++; end
    @(negedge clk);
    compared++; if (alu_read1 !== exp_rd1 || alu_control !== 6'd32) begin $display("FAIL stall_c3: read1=%h ctl=%0d want %h/32", alu_read1, alu_control, exp_rd1); mismatched++; end
    out_ready = 1; memwb_rd = 0;
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin $display("FAIL stall_drain: got %b want 0", out_valid); mismatched++; end
  endtask

  task automatic test_flush;
    @(negedge clk); out_ready = 1; flush = 1; drive(32'h2009FFFB, 32'h0, 32'h0);
    #1;
    compared++; if (in_ready !== 1'b1) begin $display("FAIL flush_ready: got %b want 1", in_ready); mismatched++; end
    @(negedge clk); flush = 0; in_valid = 0;
    compared++; if (out_valid !== 1'b0 || ex_regwrite !== 1'b0) begin $display("FAIL flush: v=%b rw=%b want 0/0", out_valid, ex_regwrite); mismatched++; end
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk); out_ready = 1; drive(32'h342A8000, 32'h1, 32'h0);
    @(negedge clk); in_valid = 0; out_ready = 0;
    compared++; if (out_valid !== 1'b1) begin $display("FAIL mid_pre: got %b want 1", out_valid); mismatched++; end
    #2 reset = 1;
    #1;
    compared++; if (out_valid !== 1'b0 || ex_rd !== 5'd0 || alu_control !== 6'd0 || alu_read1 !== 32'd0) begin $display("FAIL mid_reset: v=%b rd=%0d ctl=%0d read1=%h want 0", out_valid, ex_rd, alu_control, alu_read1); mismatched++; end
    @(negedge clk); reset = 0; out_ready = 1;
    @(negedge clk);
    compared++; if (out_valid !== 1'b0) begin $display("FAIL mid_after: got %b want 0", out_valid); mismatched++; end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_ori;
    test_forward;
    test_store_branch_nop;
    test_load_use;
    test_stall_refresh;
    test_flush;
    test_reset_mid_stall;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
